// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle IEEE-754 adder/subtractor, round-to-nearest-even,
// denormals flushed to zero, valid/ready on both sides.
// Optional build macro FP_ADDSUB_B2B_EN: accept a new operand set on the same
// edge the pending result is consumed (OUT -> ALIGN without passing through IDLE).
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a_operand,
  input  logic [EXP_W+MAN_W:0]   b_operand,
  input  logic                   AddBar_Sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   invalid,
  output logic                   overflow,
  output logic                   inexact
);

  localparam int W    = 1 + EXP_W + MAN_W;
  // Extended mantissa: hidden bit, fraction, guard, round, sticky.
  localparam int MW   = MAN_W + 4;
  localparam int LZ_W = $clog2(MW + 1);
  // Internal exponent carries headroom for the +1 bumps and the lz compare.
  localparam int XW   = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 2;

  localparam logic [XW-1:0] EXP_MAX = {{(XW-EXP_W){1'b0}}, {EXP_W{1'b1}}};
  localparam logic [W-1:0]  QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, OUT} state_t;

  state_t          state_q;
  logic [W-1:0]    a_q, b_q;
  logic            sub_q;
  logic [MW-1:0]   big_al_q, sml_al_q;
  logic            eff_sub_q;
  logic            sgn_q;
  logic [XW-1:0]   exp_q;
  logic            spec_q, spec_inv_q;
  logic [W-1:0]    spec_res_q;
  logic [MW:0]     sum_q;
  logic [MW-1:0]   man_q;
  logic            zero_q, flush_inx_q;
  logic            out_valid_q;
  logic [W-1:0]    result_q;
  logic            invalid_q, overflow_q, inexact_q;

  // ---------------- ALIGN stage signals ----------------
  logic             a_sgn, b_sgn, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
  logic [EXP_W-1:0] a_exp, b_exp, big_exp, sml_exp, exp_diff;
  logic [MAN_W:0]   a_man, b_man, big_man, sml_man;
  logic [W-2:0]     a_mag, b_mag;
  logic [MW-1:0]    sml_full, sml_shf, lost_mask;
  logic             sml_sticky, big_sgn, sml_sgn;
  logic [MW-1:0]    big_al_d, sml_al_d;
  logic             spec_d, spec_inv_d;
  logic [W-1:0]     spec_res_d;

  assign a_sgn  = a_q[W-1];
  assign b_sgn  = b_q[W-1] ^ sub_q;
  assign a_exp  = a_q[W-2:MAN_W];
  assign b_exp  = b_q[W-2:MAN_W];
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_inf  = (a_exp == '1) && (a_q[MAN_W-1:0] == '0);
  assign b_inf  = (b_exp == '1) && (b_q[MAN_W-1:0] == '0);
  assign a_nan  = (a_exp == '1) && (a_q[MAN_W-1:0] != '0);
  assign b_nan  = (b_exp == '1) && (b_q[MAN_W-1:0] != '0);
  assign a_man  = a_zero ? '0 : {1'b1, a_q[MAN_W-1:0]};
  assign b_man  = b_zero ? '0 : {1'b1, b_q[MAN_W-1:0]};
  assign a_mag  = a_zero ? '0 : a_q[W-2:0];
  assign b_mag  = b_zero ? '0 : b_q[W-2:0];
  assign swap   = (b_mag > a_mag);

  // Order operands by magnitude and align the smaller one with sticky collection
  always_comb begin
    big_exp    = swap ? b_exp : a_exp;
    sml_exp    = swap ? a_exp : b_exp;
    big_man    = swap ? b_man : a_man;
    sml_man    = swap ? a_man : b_man;
    big_sgn    = swap ? b_sgn : a_sgn;
    sml_sgn    = swap ? a_sgn : b_sgn;
    exp_diff   = big_exp - sml_exp;
    sml_full   = {sml_man, 3'b000};
    sml_shf    = sml_full >> exp_diff;
    lost_mask  = ~({MW{1'b1}} << exp_diff);
    sml_sticky = |(sml_full & lost_mask);
    big_al_d   = {big_man, 3'b000};
    if (32'(exp_diff) >= 32'(MAN_W + 3)) begin
      sml_al_d = {{(MW-1){1'b0}}, |sml_man};
    end else begin
      sml_al_d = {sml_shf[MW-1:1], sml_shf[0] | sml_sticky};
    end
  end

  // Special-operand result, resolved early and carried alongside the datapath
  always_comb begin
    spec_d     = 1'b1;
    spec_inv_d = 1'b0;
    spec_res_d = a_q;
    if (a_nan || b_nan || (a_inf && b_inf && (a_sgn != b_sgn))) begin
      spec_res_d = QNAN;
      spec_inv_d = 1'b1;
    end else if (a_inf) begin
      spec_res_d = a_q;
    end else if (b_inf) begin
      spec_res_d = {b_sgn, b_q[W-2:0]};
    end else if (a_zero && b_zero) begin
      spec_res_d = {a_sgn & b_sgn, {(W-1){1'b0}}};
    end else if (a_zero) begin
      spec_res_d = {b_sgn, b_q[W-2:0]};
    end else if (b_zero) begin
      spec_res_d = a_q;
    end else begin
      spec_d = 1'b0;
    end
  end

  // ---------------- ADD stage ----------------
  logic [MW:0] sum_d;

  // Magnitude add, or larger-minus-smaller when signs differ
  always_comb begin
    if (eff_sub_q) sum_d = {1'b0, big_al_q} - {1'b0, sml_al_q};
    else           sum_d = {1'b0, big_al_q} + {1'b0, sml_al_q};
  end

  // ---------------- NORM stage ----------------
  logic [LZ_W-1:0] lz;
  logic [MW-1:0]   norm_man_d;
  logic [XW-1:0]   norm_exp_d;
  logic            norm_sgn_d, norm_zero_d, norm_inx_d;

  // Leading-zero count: highest set bit wins since the scan runs upward
  always_comb begin
    lz = '0;
    for (int unsigned i = 0; i < MW; i++) begin
      if (sum_q[i]) lz = LZ_W'(MW - 1 - i);
    end
  end

  // Renormalise: right by one on carry, else left by lz with underflow flush
  always_comb begin
    norm_man_d  = sum_q[MW-1:0] << lz;
    norm_exp_d  = exp_q - XW'(lz);
    norm_sgn_d  = sgn_q;
    norm_zero_d = 1'b0;
    norm_inx_d  = 1'b0;
    if (sum_q[MW]) begin
      norm_man_d = {sum_q[MW:2], sum_q[1] | sum_q[0]};
      norm_exp_d = exp_q + XW'(1);
    end else if (sum_q[MW-1:0] == '0) begin
      norm_man_d  = '0;
      norm_exp_d  = '0;
      norm_sgn_d  = 1'b0;
      norm_zero_d = 1'b1;
    end else if (exp_q <= XW'(lz)) begin
      norm_man_d  = '0;
      norm_exp_d  = '0;
      norm_zero_d = 1'b1;
      norm_inx_d  = 1'b1;
    end
  end

  // ---------------- ROUND stage ----------------
  logic             round_up;
  logic [MAN_W+1:0] man_r;
  logic [XW-1:0]    exp_r;
  logic [MAN_W-1:0] frac_r;
  logic [W-1:0]     res_d;
  logic             inv_d, ovf_d, inx_d;

  // Nearest-even rounding, overflow to Inf, then special/zero overrides
  always_comb begin
    round_up = man_q[2] & (man_q[1] | man_q[0] | man_q[3]);
    man_r    = {1'b0, man_q[MW-1:3]} + (MAN_W+2)'(round_up);
    exp_r    = man_r[MAN_W+1] ? exp_q + XW'(1) : exp_q;
    frac_r   = man_r[MAN_W+1] ? man_r[MAN_W:1] : man_r[MAN_W-1:0];
    res_d    = {sgn_q, exp_r[EXP_W-1:0], frac_r};
    inv_d    = 1'b0;
    ovf_d    = 1'b0;
    inx_d    = |man_q[2:0];
    if (spec_q) begin
      res_d = spec_res_q;
      inv_d = spec_inv_q;
      inx_d = 1'b0;
    end else if (zero_q) begin
      res_d = {sgn_q, {(W-1){1'b0}}};
      inx_d = flush_inx_q;
    end else if (exp_r >= EXP_MAX) begin
      res_d = {sgn_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end
  end

  // ---------------- control ----------------
`ifdef FP_ADDSUB_B2B_EN
  assign in_ready = (state_q == IDLE) || ((state_q == OUT) && out_ready);
`else
  assign in_ready = (state_q == IDLE);
`endif

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign invalid   = invalid_q;
  assign overflow  = overflow_q;
  assign inexact   = inexact_q;

  // Fixed-latency FSM; every stage register advances once per state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      big_al_q    <= '0;
      sml_al_q    <= '0;
      eff_sub_q   <= 1'b0;
      sgn_q       <= 1'b0;
      exp_q       <= '0;
      spec_q      <= 1'b0;
      spec_inv_q  <= 1'b0;
      spec_res_q  <= '0;
      sum_q       <= '0;
      man_q       <= '0;
      zero_q      <= 1'b0;
      flush_inx_q <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      invalid_q   <= 1'b0;
      overflow_q  <= 1'b0;
      inexact_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a_operand;
            b_q     <= b_operand;
            sub_q   <= AddBar_Sub;
            state_q <= ALIGN;
          end
        end
        ALIGN: begin
          big_al_q   <= big_al_d;
          sml_al_q   <= sml_al_d;
          eff_sub_q  <= big_sgn ^ sml_sgn;
          sgn_q      <= big_sgn;
          exp_q      <= XW'(big_exp);
          spec_q     <= spec_d;
          spec_inv_q <= spec_inv_d;
          spec_res_q <= spec_res_d;
          state_q    <= ADD;
        end
        ADD: begin
          sum_q   <= sum_d;
          state_q <= NORM;
        end
        NORM: begin
          man_q       <= norm_man_d;
          exp_q       <= norm_exp_d;
          sgn_q       <= norm_sgn_d;
          zero_q      <= norm_zero_d;
          flush_inx_q <= norm_inx_d;
          state_q     <= ROUND;
        end
        ROUND: begin
          result_q    <= res_d;
          invalid_q   <= inv_d;
          overflow_q  <= ovf_d;
          inexact_q   <= inx_d;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            invalid_q   <= 1'b0;
            overflow_q  <= 1'b0;
            inexact_q   <= 1'b0;
`ifdef FP_ADDSUB_B2B_EN
            if (in_valid) begin
              a_q     <= a_operand;
              b_q     <= b_operand;
              sub_q   <= AddBar_Sub;
              state_q <= ALIGN;
            end else begin
              state_q <= IDLE;
            end
`else
            state_q <= IDLE;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Testbench for fp_addsub_seq (single precision): scoreboard of expected
// results filled at issue time and drained by an output monitor.
module tb_fp_addsub_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        AddBar_Sub = 1'b0;
  logic [31:0] a_operand = '0;
  logic [31:0] b_operand = '0;
  logic [31:0] result;
  logic        in_ready, out_valid, invalid, overflow, inexact;

  int          checks = 0;
  int          failures = 0;
  logic [34:0] sb_q[$];
  logic [34:0] mon_e;

  always #5 clk = ~clk;

  fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_operand  (a_operand),
    .b_operand  (b_operand),
    .AddBar_Sub (AddBar_Sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .invalid    (invalid),
    .overflow   (overflow),
    .inexact    (inexact)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: flags idle at zero, results compared on handshake
  always @(negedge clk) begin
    if (!reset) begin
      if (!out_valid) begin
        check_eq("flags_idle", 64'({invalid, overflow, inexact}), 64'd0);
      end else if (out_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("spurious_out", 64'(out_valid), 64'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check_eq("result",   64'(result),   64'(mon_e[34:3]));
          check_eq("invalid",  64'(invalid),  64'(mon_e[2]));
          check_eq("overflow", 64'(overflow), 64'(mon_e[1]));
          check_eq("inexact",  64'(inexact),  64'(mon_e[0]));
        end
      end
    end
  end

  // Present one operand set, push its expectation, return just after the accept edge
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] er, input logic [2:0] ef);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("accept_ready", 64'(in_ready), 64'd1);
    in_valid   = 1'b1;
    a_operand  = a;
    b_operand  = b;
    AddBar_Sub = s;
    sb_q.push_back({er, ef});
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    a_operand  = $urandom;
    b_operand  = $urandom;
    AddBar_Sub = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] er, input logic [2:0] ef);
    int lat;
    issue(a, b, s, er, ef);
    wait_out(lat);
    check_eq("latency", 64'(lat), 64'd4);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    #1 reset = 1'b1;
    #1;
    check_eq("rst_in_ready",  64'(in_ready),  64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_result",    64'(result),    64'd0);
    check_eq("rst_flags",     64'({invalid, overflow, inexact}), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // flags order: {invalid, overflow, inexact}
    run_op(32'h40A00000, 32'h40C00000, 1'b1, 32'hBF800000, 3'b000); // 5-6
    run_op(32'h4B7FFFFF, 32'h40000000, 1'b0, 32'h4B800000, 3'b001); // tie to even
    run_op(32'h4B7FFFFF, 32'h3F800000, 1'b0, 32'h4B800000, 3'b000); // exact carry
    run_op(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100); // Inf-Inf
    run_op(32'h7F800000, 32'h3EC7AE14, 1'b0, 32'h7F800000, 3'b000); // Inf+x
    run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011); // overflow
    run_op(32'h4B7FFFFF, 32'hCB7FFFFF, 1'b0, 32'h00000000, 3'b000); // cancel to +0
    run_op(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000); // 1-1
    run_op(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000); // swap, 1-2
    run_op(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001); // tie, even lsb
    run_op(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001); // tie, odd lsb
    run_op(32'h3F800000, 32'h32800000, 1'b0, 32'h3F800000, 3'b001); // sticky only
    run_op(32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 3'b000); // borrow renorm
    run_op(32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 3'b001); // underflow flush
    run_op(32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100); // NaN operand
    run_op(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100); // Inf-Inf via sub
    run_op(32'hFF800000, 32'h3F800000, 1'b1, 32'hFF800000, 3'b000); // -Inf
    run_op(32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 3'b000); // 0-B
    run_op(32'h3F800000, 32'h80000000, 1'b0, 32'h3F800000, 3'b000); // A+(-0)
    run_op(32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000); // denormal flushed

    // Backpressure: result held for 10 cycles
    out_ready = 1'b0;
    issue(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);
    wait_out(lat);
    check_eq("hold_latency", 64'(lat), 64'd4);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check_eq("hold_valid",  64'(out_valid), 64'd1);
      check_eq("hold_ready",  64'(in_ready),  64'd0);
      check_eq("hold_result", 64'(result),    64'h40000000);
      check_eq("hold_flags",  64'({invalid, overflow, inexact}), 64'd0);
    end
`ifdef FP_ADDSUB_B2B_EN
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    a_operand  = 32'h40400000;
    b_operand  = 32'h3F800000;
    AddBar_Sub = 1'b0;
    sb_q.push_back({32'h40800000, 3'b000});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_out(lat);
    check_eq("b2b_latency", 64'(lat), 64'd4);
    @(posedge clk);
    #1;
`else
    out_ready = 1'b1;
    @(posedge clk);
    #1;
`endif

    // Reset during NORM aborts the operation
    issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check_eq("abort_out_valid", 64'(out_valid), 64'd0);
    check_eq("abort_in_ready",  64'(in_ready),  64'd1);
    sb_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check_eq("post_rst_quiet", 64'(out_valid), 64'd0);
    run_op(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);

    repeat (3) @(negedge clk);
    check_eq("scoreboard_drain", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
